wb_sram_arb: RTL
================

// Module: wb_sram_arb
// PURPOSE
//  Round-robin Wishbone arbiter sharing one wb_sram slave port among NUM_MASTERS masters.
//  Sits between the CPU, DMA and debug masters and the single wb_sram slave port.
//  Grants are cycle-locked: a master keeps the slave for as long as it holds cyc.
//  An optional watchdog terminates stalled transfers.
// PARAMETERS
//  NUM_MASTERS       2   number of requesting masters (2..8)
//  WB_ADDRESS_WIDTH  32  Wishbone address width
//  WB_DATA_WIDTH     32  Wishbone data width (multiple of 8)
//  TIMEOUT_CYCLES    16  watchdog limit in cycles (used only with the macro)
// PORTS
//  clk      in   1           clock, all logic on rising edge
//  rstn     in   1           reset, synchronous, active-low
//  m_cyc    in   N           per-master cycle request
//  m_stb    in   N           per-master strobe
//  m_we     in   N           per-master write enable
//  m_sel    in   N*DW/8      per-master byte selects, master i at [i*DW/8 +: DW/8]
//  m_adr    in   N*AW        per-master addresses, packed as for m_sel
//  m_dat_w  in   N*DW        per-master write data, packed as for m_sel
//  m_dat_r  out  DW          read data, broadcast to all masters (= s_dat_r)
//  m_ack    out  N           per-master ack
//  m_err    out  N           per-master error
//  s_cyc,s_stb,s_we  out 1   slave-side controls
//  s_sel    out  DW/8        slave byte selects
//  s_adr    out  AW          slave address
//  s_dat_w  out  DW          slave write data
//  s_dat_r  in   DW          slave read data
//  s_ack    in   1           slave ack
//  s_err    in   1           slave error
//  grant    out  N           registered one-hot current owner (0 = none)
// BEHAVIOUR
//  Reset (rstn=0 at a clk edge):
//   - grant=0, state=IDLE, last=N-1 (master 0 has first priority).
//   - All s_* outputs and all m_ack/m_err are 0 while reset is asserted.
//   - Reset mid-transfer abandons the transfer; no ack/err reaches any master.
//  IDLE state:
//   - If any m_cyc is set, pick the first set bit scanning last+1, last+2, ... mod N.
//   - Register the pick into grant and last; go to OWN.
//   - Request at edge k gives grant at edge k+1; s_cyc/s_stb are visible from that cycle.
//  OWN state:
//   - s_cyc/s_stb/s_we/s_sel/s_adr/s_dat_w come combinationally from master g
//     (g = index of grant), gated by m_cyc[g].
//   - m_ack[g] = s_ack & m_cyc[g]; m_err[g] = s_err & m_cyc[g].
//   - ack/err to every other master is 0.
//  Release:
//   - When m_cyc[g]=0 at an edge: grant=0, go to IDLE.
//   - There is always at least one dead cycle between owners.
//   - An ack arriving in the cycle cyc drops is discarded.
//  Other rules:
//   - Requests from non-owners never pre-empt the owner.
//   - A single requester is re-granted after each one-cycle IDLE.
//   - m_cyc that rises and falls while not granted is ignored (no ack, no err).
// CONFIGURATION
//  WB_SRAM_ARB_TIMEOUT_EN defined:
//   - Counter clears on grant, on s_ack/s_err, or when s_stb=0; otherwise it increments.
//   - At TIMEOUT_CYCLES-1: pulse m_err[g] for 1 cycle, force s_stb=0 that cycle, clear counter.
//   - Grant is kept until the master drops cyc.
//  Not defined: no counter is built and err is a pure pass-through of s_err.
// TESTING
//  - Reset, M0 and M1 raise cyc at the same edge -> M0 granted at the next edge;
//    M1 granted 1 idle cycle after M0 drops cyc.
//  - M1 holds cyc for a 4-beat read burst while M0 requests
//    -> M1 receives all 4 acks with s_dat_r data; M0 gets no ack until M1 releases.
//  - M0 repeatedly requests, M1 requests once -> order M0,M1,M0 (round-robin proven).
//  - M0 writes 0xDEADBEEF, sel=4'b0011 at addr 0x10; M1 reads 0x10
//    -> M1 reads 0x????BEEF with the upper bytes holding their previous value.
//  - rstn=0 mid-burst of M1 -> next cycle grant=0, s_cyc=0; after release, M0 wins first.
//  - With WB_SRAM_ARB_TIMEOUT_EN and slave ack stuck at 0
//    -> m_err[g] pulses exactly 16 cycles after s_stb rises.

Source files
------------

// File: rtl/wb_sram_arb.sv
// Round-robin, cycle-locked Wishbone arbiter in front of a single wb_sram slave port.
// Define WB_SRAM_ARB_TIMEOUT_EN to add a watchdog that errors out stalled strobes.
module wb_sram_arb #(
  parameter int NUM_MASTERS      = 2,
  parameter int WB_ADDRESS_WIDTH = 32,
  parameter int WB_DATA_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES   = 16
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic [NUM_MASTERS-1:0]                    m_cyc,
  input  logic [NUM_MASTERS-1:0]                    m_stb,
  input  logic [NUM_MASTERS-1:0]                    m_we,
  input  logic [NUM_MASTERS*WB_DATA_WIDTH/8-1:0]    m_sel,
  input  logic [NUM_MASTERS*WB_ADDRESS_WIDTH-1:0]   m_adr,
  input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0]      m_dat_w,
  output logic [WB_DATA_WIDTH-1:0]                  m_dat_r,
  output logic [NUM_MASTERS-1:0]                    m_ack,
  output logic [NUM_MASTERS-1:0]                    m_err,
  output logic                                      s_cyc,
  output logic                                      s_stb,
  output logic                                      s_we,
  output logic [WB_DATA_WIDTH/8-1:0]                s_sel,
  output logic [WB_ADDRESS_WIDTH-1:0]               s_adr,
  output logic [WB_DATA_WIDTH-1:0]                  s_dat_w,
  input  logic [WB_DATA_WIDTH-1:0]                  s_dat_r,
  input  logic                                      s_ack,
  input  logic                                      s_err,
  output logic [NUM_MASTERS-1:0]                    grant
);

  localparam int N  = NUM_MASTERS;
  localparam int AW = WB_ADDRESS_WIDTH;
  localparam int DW = WB_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  grant_nxt;
  logic [IW-1:0] last, last_nxt, pick;
  logic          pick_vld;
  logic          cyc_g, stb_raw, to_hit;

  // While OWN, last is the index of the current owner.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = N; i >= 1; i--) begin
      if (m_cyc[IW'((int'(last) + i) % N)]) begin
        pick     = IW'((int'(last) + i) % N);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    case (state)
      IDLE: if (pick_vld) begin
        state_nxt = OWN;
        grant_nxt = {{(N-1){1'b0}}, 1'b1} << pick;
        last_nxt  = pick;
      end
      OWN: if (!m_cyc[last]) begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      grant <= '0;
      last  <= IW'(N - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end

  assign cyc_g   = (state == OWN) && rstn && m_cyc[last];
  assign stb_raw = cyc_g && m_stb[last];

`ifdef WB_SRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;

  assign to_hit = stb_raw && !s_ack && !s_err && (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Idle cycles, completed beats and a fired timeout all restart the count.
  always_ff @(posedge clk) begin
    if (!rstn || state != OWN || !stb_raw || s_ack || s_err || to_hit)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + CW'(1);
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    s_cyc   = cyc_g;
    s_stb   = stb_raw && !to_hit;
    s_we    = cyc_g && m_we[last];
    s_sel   = '0;
    s_adr   = '0;
    s_dat_w = '0;
    m_ack   = '0;
    m_err   = '0;
    if (cyc_g) begin
      s_sel       = m_sel[int'(last)*SW +: SW];
      s_adr       = m_adr[int'(last)*AW +: AW];
      s_dat_w     = m_dat_w[int'(last)*DW +: DW];
      m_ack[last] = s_ack;
      m_err[last] = s_err || to_hit;
    end
  end

  assign m_dat_r = s_dat_r;

endmodule
